// File: rtl/b12_pkg.sv
// b12_pkg: sound codes, tone half-period limits and scheduler state encoding
package b12_pkg;

    localparam logic [2:0] S_RED = 3'd0, S_GREEN = 3'd1, S_YELLOW = 3'd2,
                           S_BLUE = 3'd3, S_WIN = 3'd4, S_LOSS = 3'd5;

    localparam logic [2:0] L_RED = 3'd2, L_GREEN = 3'd3, L_YELLOW = 3'd4,
                           L_BLUE = 3'd5, L_WIN = 3'd6, L_LOSS = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Codes above LOSS carry no tone; their duration still elapses
    function automatic logic tone_silent(input logic [2:0] code);
        return code > S_LOSS;
    endfunction

    // Counter limit per code; the half-period is limit + 2 cycles
    function automatic logic [2:0] tone_limit(input logic [2:0] code);
        return (code == S_RED)    ? L_RED    :
               (code == S_GREEN)  ? L_GREEN  :
               (code == S_YELLOW) ? L_YELLOW :
               (code == S_BLUE)   ? L_BLUE   :
               (code == S_WIN)    ? L_WIN    :
               (code == S_LOSS)   ? L_LOSS   : 3'd7;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave generator for one sound code, cleared while disabled
module tone_divider
    import b12_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] code,
    output logic       speaker
);

    logic [2:0] cnt_q, cnt_d;
    logic       spk_q, spk_d;
    logic       wrap;

    assign wrap = cnt_q > tone_limit(code);

    // Count past the limit, then flip the output and restart from zero
    always_comb begin
        cnt_d = 3'd0;
        spk_d = 1'b0;
        if (enable) begin
            cnt_d = wrap ? 3'd0 : cnt_q + 3'd1;
            spk_d = tone_silent(code) ? 1'b0 : spk_q ^ wrap;
        end
    end

    // Counter and output flop; reset forces silence at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 3'd0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end

    assign speaker = spk_q;

endmodule

// File: rtl/tone_sched.sv
// tone_sched: arbitrates tone requests onto the shared speaker with a silent gap
module tone_sched
    import b12_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int LEN_W       = 6,
    parameter int GAP_CYCLES  = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [3*NUM_REQ-1:0]     req_sound,
    input  logic [LEN_W*NUM_REQ-1:0] req_len,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [1:0]               gnt_id,
    output logic                     speaker
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   dur_q, dur_d;
    logic [2:0]         snd_q, snd_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [LEN_W-1:0]   len_sel;
    logic               found;
    logic [1:0]         win;
    int                 idx;
    logic               tone_en;

    // Pick the winner: lowest index, or first index after the last grantee
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ROUND_ROBIN != 0) ? (int'(gnt_q) + 1 + k) % NUM_REQ : k;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    // Next-state logic; the duration counter is reused to time the gap
    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        snd_d   = snd_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        done_d  = '0;
        len_sel = req_len[LEN_W*int'(win) +: LEN_W];
        if (state_q == ST_IDLE) begin
            if (found) begin
                state_d    = ST_PLAY;
                gnt_d      = win;
                snd_d      = req_sound[3*int'(win) +: 3];
                dur_d      = (len_sel == '0) ? ONE : len_sel;
                ack_d[win] = 1'b1;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
            dur_d   = '0;
        end else if (dur_q > ONE) begin
            dur_d = dur_q - ONE;
        end else if (state_q == ST_PLAY) begin
            done_d[gnt_q] = 1'b1;
            state_d       = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            dur_d         = LEN_W'(GAP_CYCLES);
        end else begin
            state_d = ST_IDLE;
            dur_d   = '0;
        end
        busy_d = state_d != ST_IDLE;
    end

    // Tone runs only while PLAY continues, so grant, completion and abort all silence it
    assign tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY);

    // Scheduler state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            snd_q   <= 3'd0;
            gnt_q   <= 2'd0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            snd_q   <= snd_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    tone_divider u_div (
        .clock   (clock),
        .reset   (reset),
        .enable  (tone_en),
        .code    (snd_q),
        .speaker (speaker)
    );

    assign ack    = ack_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_tone_sched.sv
// tb_tone_sched: directed vectors for fixed, round-robin and zero-gap schedulers
module tb_tone_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [8:0]  req_sound = '0;
    logic [17:0] req_len = '0;
    logic        abort = 1'b0;

    logic [2:0] ack_f, done_f, ack_r, done_r, ack_z, done_z;
    logic       busy_f, busy_r, busy_z, spk_f, spk_r, spk_z;
    logic [1:0] gid_f, gid_r, gid_z;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    tone_sched #(.ROUND_ROBIN(0), .GAP_CYCLES(2)) u_f (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_sound(req_sound),
        .req_len(req_len), .abort(abort), .ack(ack_f), .done(done_f), .busy(busy_f),
        .gnt_id(gid_f), .speaker(spk_f));

    tone_sched #(.ROUND_ROBIN(1), .GAP_CYCLES(2)) u_r (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_sound(req_sound),
        .req_len(req_len), .abort(abort), .ack(ack_r), .done(done_r), .busy(busy_r),
        .gnt_id(gid_r), .speaker(spk_r));

    tone_sched #(.ROUND_ROBIN(0), .GAP_CYCLES(0)) u_z (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_sound(req_sound),
        .req_len(req_len), .abort(abort), .ack(ack_z), .done(done_z), .busy(busy_z),
        .gnt_id(gid_z), .speaker(spk_z));

    typedef struct {
        logic [2:0] valid;
        logic [2:0] fix_ack;
        logic [1:0] fix_id;
        logic [2:0] rr_ack;
        logic [1:0] rr_id;
    } arb_vec_t;

    typedef struct {
        int         idx;
        logic [2:0] snd;
        int         len;
        int         half;
    } tone_vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 3'b000;
        abort     = 1'b0;
        req_sound = '0;
        req_len   = '0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    // Grant one tone on the fixed-priority unit and check every PLAY and GAP cycle
    task automatic play(input tone_vec_t v);
        int         n;
        logic [2:0] oh;
        logic       es;
        do_reset();
        oh = 3'b001 << v.idx;
        req_sound[3*v.idx +: 3] = v.snd;
        req_len[6*v.idx +: 6]   = 6'(v.len);
        req_valid = oh;
        tick();
        req_valid = 3'b000;
        chk("grant_id", 32'(gid_f), 32'(v.idx));
        n = (v.len == 0) ? 1 : v.len;
        for (int c = 1; c <= n; c++) begin
            es = (v.half == 0) ? 1'b0 : 1'(((c - 1) / v.half) % 2);
            chk($sformatf("play_s%0d_c%0d", v.snd, c), 32'({ack_f, busy_f, done_f, spk_f}),
                32'({(c == 1) ? oh : 3'b000, 1'b1, 3'b000, es}));
            tick();
        end
        chk("done_pulse", 32'({busy_f, done_f, spk_f}), 32'({1'b1, oh, 1'b0}));
        tick();
        chk("gap2", 32'({busy_f, done_f, spk_f}), 32'({1'b1, 3'b000, 1'b0}));
        tick();
        chk("idle_after_gap", 32'({busy_f, done_f}), 32'({1'b0, 3'b000}));
    endtask

    initial begin
        arb_vec_t  av[7];
        tone_vec_t tv[9];
        av[0] = '{3'b001, 3'b001, 2'd0, 3'b001, 2'd0};
        av[1] = '{3'b010, 3'b010, 2'd1, 3'b010, 2'd1};
        av[2] = '{3'b100, 3'b100, 2'd2, 3'b100, 2'd2};
        av[3] = '{3'b011, 3'b001, 2'd0, 3'b010, 2'd1};
        av[4] = '{3'b101, 3'b001, 2'd0, 3'b100, 2'd2};
        av[5] = '{3'b110, 3'b010, 2'd1, 3'b010, 2'd1};
        av[6] = '{3'b111, 3'b001, 2'd0, 3'b010, 2'd1};
        tv[0] = '{1, 3'd0, 20, 4};
        tv[1] = '{0, 3'd5, 12, 3};
        tv[2] = '{2, 3'd7, 12, 0};
        tv[3] = '{0, 3'd4, 20, 8};
        tv[4] = '{2, 3'd3, 14, 7};
        tv[5] = '{1, 3'd1, 10, 5};
        tv[6] = '{0, 3'd2, 12, 6};
        tv[7] = '{1, 3'd6, 5, 0};
        tv[8] = '{0, 3'd0, 0, 4};

        // Reset with all requests held: everything quiet, then requester 0 wins
        reset     = 1'b0;
        req_valid = 3'b111;
        req_len   = {6'd3, 6'd3, 6'd3};
        repeat (2) tick();
        chk("reset_fix", 32'({ack_f, done_f, busy_f, gid_f, spk_f}), 32'(0));
        chk("reset_rr", 32'({ack_r, done_r, busy_r, gid_r, spk_r}), 32'(0));
        reset = 1'b1;
        chk("no_ack_before_edge", 32'(ack_f), 32'(0));
        tick();
        chk("first_ack_fix", 32'(ack_f), 32'(3'b001));
        chk("first_ack_rr", 32'(ack_r), 32'(3'b010));
        req_valid = 3'b000;

        // Winner selection from IDLE for every request pattern
        for (int i = 0; i < 7; i++) begin
            do_reset();
            req_len   = {6'd2, 6'd2, 6'd2};
            req_valid = av[i].valid;
            tick();
            req_valid = 3'b000;
            chk($sformatf("fix_ack_%b", av[i].valid), 32'(ack_f), 32'(av[i].fix_ack));
            chk($sformatf("fix_id_%b", av[i].valid), 32'(gid_f), 32'(av[i].fix_id));
            chk($sformatf("rr_ack_%b", av[i].valid), 32'(ack_r), 32'(av[i].rr_ack));
            chk($sformatf("rr_id_%b", av[i].valid), 32'(gid_r), 32'(av[i].rr_id));
            chk($sformatf("busy_%b", av[i].valid), 32'({busy_f, busy_r}), 32'(2'b11));
        end

        // Tone shapes, silent codes and zero length
        for (int i = 0; i < 9; i++) play(tv[i]);

        // Rotation versus fixed priority with requesters 0 and 2 held
        do_reset();
        req_len   = {6'd1, 6'd1, 6'd1};
        req_valid = 3'b100;
        tick();
        chk("rr_seed", 32'({ack_r, ack_f}), 32'({3'b100, 3'b100}));
        req_valid = 3'b101;
        for (int g = 0; g < 4; g++) begin
            tick();
            for (int w = 0; w < 12 && ack_r == 3'b000; w++) tick();
            chk($sformatf("rr_seq%0d", g), 32'(ack_r), 32'((g % 2 == 0) ? 3'b001 : 3'b100));
            chk($sformatf("fix_seq%0d", g), 32'(ack_f), 32'(3'b001));
        end
        req_valid = 3'b000;

        // Abort in PLAY with a pending request, which is granted right after
        do_reset();
        req_len   = {6'd20, 6'd20, 6'd3};
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        repeat (4) tick();
        chk("abort_pre_spk", 32'(spk_f), 32'(1));
        abort     = 1'b1;
        req_valid = 3'b001;
        tick();
        abort = 1'b0;
        chk("abort_idle", 32'({ack_f, done_f, busy_f, spk_f}), 32'(0));
        tick();
        req_valid = 3'b000;
        chk("abort_regrant", 32'({ack_f, busy_f, gid_f}), 32'({3'b001, 1'b1, 2'd0}));
        repeat (3) tick();
        chk("abort_next_done", 32'(done_f), 32'(3'b001));

        // Abort in GAP ends the gap on the next edge
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_gap", 32'({busy_f, done_f, spk_f}), 32'(0));

        // Abort in IDLE is ignored and a same-cycle request still wins
        do_reset();
        req_len   = {6'd4, 6'd4, 6'd4};
        abort     = 1'b1;
        req_valid = 3'b100;
        tick();
        abort     = 1'b0;
        req_valid = 3'b000;
        chk("abort_in_idle", 32'({ack_f, busy_f, gid_f}), 32'({3'b100, 1'b1, 2'd2}));

        // Zero gap, length 1, valid held: acks two cycles apart
        do_reset();
        req_len   = {6'd1, 6'd1, 6'd1};
        req_valid = 3'b001;
        tick();
        chk("b2b_ack1", 32'({ack_z, busy_z}), 32'({3'b001, 1'b1}));
        tick();
        chk("b2b_idle", 32'({ack_z, done_z, busy_z}), 32'({3'b000, 3'b001, 1'b0}));
        tick();
        chk("b2b_ack2", 32'({ack_z, busy_z}), 32'({3'b001, 1'b1}));
        req_valid = 3'b000;

        // Asynchronous reset mid-PLAY: instant silence, no completion
        do_reset();
        req_len   = {6'd20, 6'd20, 6'd20};
        req_valid = 3'b001;
        tick();
        req_valid = 3'b000;
        repeat (4) tick();
        chk("mid_pre_spk", 32'(spk_f), 32'(1));
        reset = 1'b0;
        #1;
        chk("mid_reset_async", 32'({spk_f, busy_f, done_f, ack_f}), 32'(0));
        tick();
        reset = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (done_f != 3'b000 || busy_f) chk("mid_reset_quiet", 32'({busy_f, done_f}), 32'(0));
            tick();
        end
        chk("mid_reset_end", 32'({busy_f, done_f, spk_f}), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/tone_sched.md
Name: tone_sched

Overview:
- Scheduler that shares the single game speaker among several sound requesters: sequence playback, key echo and the win/loss jingle.
- Accepts tone requests over a valid/ack handshake and arbitrates between them.
- Plays each granted tone for a requested number of clock cycles, then enforces a silent gap before the next grant.
- Sits between the game controller FSM and the speaker pin; the controller no longer drives the speaker directly.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is the highest fixed priority.
- LEN_W, 6, width of the duration field per request.
- GAP_CYCLES, 2, silent cycles forced after each tone (0 = none).
- ROUND_ROBIN, 0, 0 = fixed priority, 1 = rotating priority starting after the last grantee.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until the matching ack is seen.
- req_sound  in  3*NUM_REQ  sound code per requester, packed; requester i uses bits [3i+2:3i].
- req_len  in  LEN_W*NUM_REQ  tone duration in cycles per requester, packed.
- abort  in  1  terminates the current tone or gap immediately.
- ack  out  NUM_REQ  one-cycle grant pulse.
- done  out  NUM_REQ  one-cycle completion pulse.
- busy  out  1  high in PLAY and GAP.
- gnt_id  out  2  index of the current or last grantee.
- speaker  out  1  square-wave output.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, speaker=0, ack=0, done=0, busy=0, gnt_id=0, tone and duration counters=0, RR pointer=0.
- States: IDLE, PLAY, GAP.
- IDLE:
  - If any req_valid=1, the winner is chosen on that edge.
  - Fixed mode: lowest set index wins. RR mode: first set index at or after last_grant+1, modulo NUM_REQ.
  - On the same edge: latch sound and duration, set gnt_id, ack[winner]=1 for exactly one cycle, state to PLAY, busy=1, tone counter=0, speaker=0.
  - A latched length of 0 is treated as 1.
  - Latency: request visible in cycle n, ack and PLAY in cycle n+1.
- PLAY:
  - The duration counter decrements each cycle, so PLAY lasts exactly len cycles.
  - On the final PLAY cycle's edge: done[gnt_id]=1 for one cycle, speaker=0, and state goes to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
- Tone generation in PLAY:
  - Each code has a limit L: 0→2, 1→3, 2→4, 3→5, 4 (WIN)→6, 5 (LOSS)→1.
  - If tone counter > L: speaker toggles and the counter clears. Otherwise the counter increments (3-bit).
  - Half-period is therefore L+2 cycles.
  - Codes 6 and 7 are silent: speaker stays 0 and the duration still elapses.
- GAP: speaker=0, counts GAP_CYCLES cycles, then IDLE. req_valid is ignored in PLAY and GAP.
- Simultaneous events:
  - abort has priority over completion. abort=1 in PLAY or GAP → IDLE on the next edge, speaker=0, busy=0, no done pulse.
  - abort in IDLE is ignored, and a request in the same cycle is still granted.
- Requester contract:
  - The requester drops req_valid in the cycle ack is seen.
  - len=1 with GAP_CYCLES=0 gives IDLE one cycle after ack; a requester still holding valid there is granted again (legal back-to-back).
- RR pointer updates only on a grant.
- Async reset mid-PLAY: speaker goes to 0 immediately and no done pulse is issued.

Decomposition:
- Shared package b12_pkg holds:
  - sound codes S_RED=0, S_GREEN=1, S_YELLOW=2, S_BLUE=3, S_WIN=4, S_LOSS=5;
  - the tone limit constants;
  - the state encoding.
- Sub-module tone_divider (inputs: clock, reset, enable, code; output: speaker) holds the tone counter and toggle flop; enable=0 clears both.

Test Plan:
- Reset with req_valid=3'b111 held → all outputs 0 while reset=0; after release, ack=3'b001 one cycle later (fixed mode).
- Req1: sound=0, len=20, GAP=2 → ack[1] in cycle n+1, speaker toggles every 4 cycles, done[1] after 20 PLAY cycles, 2 silent cycles, then IDLE.
- Req0 and req2 both valid, ROUND_ROBIN=1 → grants alternate 0, 2, 0, 2; with ROUND_ROBIN=0 → 0, 0, 0.
- Sound=5, len=12 → speaker period 6 cycles; sound=7 → speaker stays 0, done still pulses at 12 cycles.
- abort in cycle 5 of PLAY → IDLE next edge, speaker=0, busy=0, no done pulse; a pending request is acked on the following edge.
- len=0 → exactly 1 PLAY cycle and a done pulse; len=1 with GAP=0 and valid held → back-to-back acks 2 cycles apart.
